// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory slave for the 16-bit pipelined PMIPS core. Each access
// completes in a single cycle with no wait states and goes to one of:
//   * word RAM, 2^AW words of 16 bits, at byte addresses 0 .. 2^(AW+1)-1
//   * a 16-byte memory-mapped I/O page at IO_BASE:
//       +0 LED     R/W, low 8 bits drive the board LEDs
//       +2 SW      RO,  switch inputs after a 2-flop synchronizer
//       +4 COUNT   R/W, free-running 16-bit timer
//       +6 CMP     R/W, timer compare value
//       +8 STATUS  bit0 match (sticky, W1C), bit1 error (sticky, W1C),
//                  bit2 timer enable (R/W)
//   * nothing (unmapped): reads return 0, writes are dropped, error is set.
// Read data is combinational, so the core's MEM/WB register captures it at
// the posedge that ends the access cycle. A read and a write in the same
// cycle return the pre-write value.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous, active-high; clears every register but not RAM
//   dmemaddr    byte address from the core's EX/MEM stage
//   dmemwdata   write data
//   dmemwrite   write enable, sampled at posedge
//   dmemread    read enable; dmemrdata is 0 while it is low
//   dmemrdata   combinational read data
//   sw          asynchronous board switches
//   leds        LED register
//   timer_flag  STATUS[0] (timer match)
//   err_flag    STATUS[1] (misaligned or unmapped access)
// ----------------------------------------------------------------------------
module dmem_responder #(
   parameter int          AW      = 7,
   parameter logic [15:0] IO_BASE = 16'hFFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] dmemaddr,
   input  logic [15:0] dmemwdata,
   input  logic        dmemwrite,
   input  logic        dmemread,
   output logic [15:0] dmemrdata,
   input  logic [7:0]  sw,
   output logic [7:0]  leds,
   output logic        timer_flag,
   output logic        err_flag
);

   localparam int RAM_WORDS = 1 << AW;

   // Word offsets inside the I/O page (dmemaddr[3:1]); 5..7 are unused.
   typedef enum logic [2:0] {
      IO_LED    = 3'd0,
      IO_SW     = 3'd1,
      IO_COUNT  = 3'd2,
      IO_CMP    = 3'd3,
      IO_STATUS = 3'd4
   } io_reg_e;

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   logic [15:0] mem_q [RAM_WORDS];

   logic [7:0]  led_q,     led_d;
   logic [7:0]  sw_meta_q;
   logic [7:0]  sw_sync_q;
   logic [15:0] count_q,   count_d;
   logic [15:0] cmp_q,     cmp_d;
   logic        match_q,   match_d;
   logic        err_q,     err_d;
   logic        en_q,      en_d;

   // -------------------------------------------------------------------------
   // Address decode
   // -------------------------------------------------------------------------
   logic [AW-1:0] word_idx;
   logic [2:0]    io_off;
   logic          ram_sel;
   logic          io_page;
   logic          io_sel;
   logic          unmapped;
   logic          access;
   logic          misaligned;
   logic          err_set;

   // Bit 0 is simply dropped: a misaligned access is carried out on the
   // containing word and only flagged through STATUS[1].
   assign word_idx   = dmemaddr[AW:1];
   assign io_off     = dmemaddr[3:1];
   assign misaligned = dmemaddr[0];

   assign ram_sel  = (dmemaddr >> (AW + 1)) == 16'd0;
   assign io_page  = dmemaddr[15:4] == IO_BASE[15:4];
   assign io_sel   = !ram_sel && io_page && (io_off <= IO_STATUS);
   assign unmapped = !ram_sel && !io_sel;

   assign access  = dmemread || dmemwrite;
   assign err_set = access && (misaligned || unmapped);

   // Per-register write strobes. The SW register has no strobe: writes to
   // it are legal but have no effect.
   logic wr_led;
   logic wr_count;
   logic wr_cmp;
   logic wr_status;
   logic wr_ram;

   assign wr_led    = dmemwrite && io_sel && (io_off == IO_LED);
   assign wr_count  = dmemwrite && io_sel && (io_off == IO_COUNT);
   assign wr_cmp    = dmemwrite && io_sel && (io_off == IO_CMP);
   assign wr_status = dmemwrite && io_sel && (io_off == IO_STATUS);
   assign wr_ram    = dmemwrite && ram_sel;

   // -------------------------------------------------------------------------
   // Timer
   // -------------------------------------------------------------------------
   // The compare always uses the registered COUNT and CMP, so a CPU write
   // to either one only influences matching from the following cycle.
   logic timer_hit;

   assign timer_hit = en_q && (count_q == cmp_q);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      led_d   = led_q;
      count_d = count_q;
      cmp_d   = cmp_q;
      match_d = match_q;
      err_d   = err_q;
      en_d    = en_q;

      if (wr_led) begin
         led_d = dmemwdata[7:0];
      end

      if (wr_cmp) begin
         cmp_d = dmemwdata;
      end

      // Hardware count/reload, then a CPU write overrides it.
      if (en_q) begin
         count_d = timer_hit ? 16'd0 : count_q + 16'd1;
      end
      if (wr_count) begin
         count_d = dmemwdata;
      end

      // W1C on the sticky bits first, then hardware sets on top so a set
      // that coincides with a clear is never lost.
      if (wr_status) begin
         match_d = match_q & ~dmemwdata[0];
         err_d   = err_q   & ~dmemwdata[1];
         en_d    = dmemwdata[2];
      end
      match_d = match_d | timer_hit;
      err_d   = err_d   | err_set;
   end

   // -------------------------------------------------------------------------
   // Register state
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values present before the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         led_q     <= 8'h00;
         sw_meta_q <= 8'h00;
         sw_sync_q <= 8'h00;
         count_q   <= 16'd0;
         cmp_q     <= 16'hFFFF;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         match_q   <= match_d;
         err_q     <= err_d;
         en_q      <= en_d;
      end
   end

   // NOTE: the RAM array has no reset so it maps onto plain memory; reset
   // only blocks a write that lands in the same cycle.
   always_ff @(posedge clock) begin
      if (!reset && wr_ram) begin
         mem_q[word_idx] <= dmemwdata;
      end
   end

   // -------------------------------------------------------------------------
   // Read path (combinational, pre-write values)
   // -------------------------------------------------------------------------
   always_comb begin
      dmemrdata = 16'h0000;
      if (dmemread) begin
         if (ram_sel) begin
            dmemrdata = mem_q[word_idx];
         end else if (io_sel) begin
            case (io_off)
               IO_LED:    dmemrdata = {8'h00, led_q};
               IO_SW:     dmemrdata = {8'h00, sw_sync_q};
               IO_COUNT:  dmemrdata = count_q;
               IO_CMP:    dmemrdata = cmp_q;
               IO_STATUS: dmemrdata = {13'd0, en_q, err_q, match_q};
               default:   dmemrdata = 16'h0000;
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign leds       = led_q;
   assign timer_flag = match_q;
   assign err_flag   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// Bench for dmem_responder. Stimulus runs one access per cycle; for each
// cycle a reference model of the memory map predicts dmemrdata, leds and the
// two flags and pushes that prediction into a queue. A monitor on the falling
// edge pops one prediction per cycle and compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          AW        = 7;
   localparam int          RAM_BYTES = 2 ** (AW + 1);
   localparam logic [15:0] IO_BASE   = 16'hFFF0;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic [15:0] dmemaddr  = 16'h0000;
   logic [15:0] dmemwdata = 16'h0000;
   logic        dmemwrite = 1'b0;
   logic        dmemread  = 1'b0;
   logic [7:0]  sw        = 8'h00;
   logic [15:0] dmemrdata;
   logic [7:0]  leds;
   logic        timer_flag;
   logic        err_flag;

   dmem_responder #(.AW(AW), .IO_BASE(IO_BASE)) dut (
      .clock      (clock),
      .reset      (reset),
      .dmemaddr   (dmemaddr),
      .dmemwdata  (dmemwdata),
      .dmemwrite  (dmemwrite),
      .dmemread   (dmemread),
      .dmemrdata  (dmemrdata),
      .sw         (sw),
      .leds       (leds),
      .timer_flag (timer_flag),
      .err_flag   (err_flag)
   );

   always #5 clock = ~clock;

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   typedef struct {
      int          cyc;
      logic [15:0] rdata;
      logic [7:0]  leds;
      logic        tf;
      logic        ef;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic check(input string name, input int c,
                        input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rdata",      e.cyc, dmemrdata,                 e.rdata);
         check("leds",       e.cyc, {8'h00, leds},             {8'h00, e.leds});
         check("timer_flag", e.cyc, {15'd0, timer_flag},       {15'd0, e.tf});
         check("err_flag",   e.cyc, {15'd0, err_flag},         {15'd0, e.ef});
      end
   end

   // -------------------------------------------------------------------------
   // Reference model: the memory map as plain variables
   // -------------------------------------------------------------------------
   logic [15:0] m_ram [RAM_BYTES / 2];
   logic [7:0]  m_led;
   logic [7:0]  m_sw_hist[$];   // switch samples of the last two edges, oldest first
   logic [15:0] m_count;
   logic [15:0] m_cmp;
   logic        m_match;
   logic        m_err;
   logic        m_en;

   task automatic m_reset();
      m_led     = 8'h00;
      m_sw_hist = '{8'h00, 8'h00};
      m_count   = 16'd0;
      m_cmp     = 16'hFFFF;
      m_match   = 1'b0;
      m_err     = 1'b0;
      m_en      = 1'b0;
   endtask

   // -1 unmapped, 0 RAM, 1 I/O register (offset returned separately)
   function automatic int region(input logic [15:0] addr, output int off);
      int a;
      a   = int'(addr) & ~1;
      off = 0;
      if (a < RAM_BYTES) return 0;
      if (a >= int'(IO_BASE) && (a - int'(IO_BASE)) <= 8) begin
         off = a - int'(IO_BASE);
         return 1;
      end
      return -1;
   endfunction

   function automatic logic [15:0] m_read(input bit rd, input logic [15:0] addr);
      int off;
      int r;
      if (!rd) return 16'h0000;
      r = region(addr, off);
      if (r == 0) return m_ram[(int'(addr) & ~1) / 2];
      if (r == 1) begin
         case (off)
            0: return {8'h00, m_led};
            2: return {8'h00, m_sw_hist[0]};
            4: return m_count;
            6: return m_cmp;
            8: return {13'd0, m_en, m_err, m_match};
            default: return 16'h0000;
         endcase
      end
      return 16'h0000;
   endfunction

   // Effect of one rising clock edge with the given inputs.
   task automatic m_step(input bit rst, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [7:0] swv);
      int          off;
      int          r;
      bit          hit;
      bit          bad_access;
      logic [15:0] next_count;
      if (rst) begin
         m_reset();
         return;
      end
      r          = region(addr, off);
      bad_access = (rd || wr) && (addr[0] || r < 0);
      hit        = m_en && (m_count == m_cmp);
      next_count = m_count;
      if (m_en) next_count = hit ? 16'd0 : m_count + 16'd1;
      if (wr && r == 0) m_ram[(int'(addr) & ~1) / 2] = wd;
      if (wr && r == 1) begin
         case (off)
            0: m_led = wd[7:0];
            4: next_count = wd;
            6: m_cmp = wd;
            8: begin
               if (wd[0]) m_match = 1'b0;
               if (wd[1]) m_err   = 1'b0;
               m_en = wd[2];
            end
            default: ;
         endcase
      end
      if (hit)        m_match = 1'b1;
      if (bad_access) m_err   = 1'b1;
      m_count = next_count;
      m_sw_hist.push_back(swv);
      void'(m_sw_hist.pop_front());
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   task automatic cycle(input bit rst, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [7:0] swv);
      exp_t e;
      @(posedge clock);
      #1;
      reset     = rst;
      dmemread  = rd;
      dmemwrite = wr;
      dmemaddr  = addr;
      dmemwdata = wd;
      sw        = swv;
      cyc++;
      e.cyc   = cyc;
      e.rdata = m_read(rd, addr);
      e.leds  = m_led;
      e.tf    = m_match;
      e.ef    = m_err;
      exp_q.push_back(e);
      m_step(rst, rd, wr, addr, wd, swv);
   endtask

   task automatic wr_op(input logic [15:0] addr, input logic [15:0] wd);
      cycle(1'b0, 1'b0, 1'b1, addr, wd, sw);
   endtask

   task automatic rd_op(input logic [15:0] addr);
      cycle(1'b0, 1'b1, 1'b0, addr, 16'h0000, sw);
   endtask

   task automatic idle(input logic [7:0] swv);
      cycle(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, swv);
   endtask

   initial begin
      m_reset();

      // Reset and basic RAM traffic
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
      wr_op(16'h0004, 16'h1234);
      wr_op(16'h0006, 16'hBEEF);
      rd_op(16'h0004);
      rd_op(16'h0006);
      idle(8'h00);

      // LED, switch synchronizer, ignored SW write
      wr_op(16'hFFF0, 16'h00A5);
      idle(8'h3C);
      idle(8'h3C);
      rd_op(16'hFFF2);
      wr_op(16'hFFF2, 16'h5555);
      idle(8'h3C);

      // Timer runs to CMP, wraps, sets match; then clear match keeping enable
      wr_op(16'hFFF6, 16'h0003);
      wr_op(16'hFFF4, 16'h0000);
      wr_op(16'hFFF8, 16'h0004);
      for (int i = 0; i < 5; i++) rd_op(16'hFFF4);
      wr_op(16'hFFF8, 16'h0005);
      rd_op(16'hFFF8);

      // Errors: unmapped read, misaligned write, clear error
      rd_op(16'h0101);
      wr_op(16'h0003, 16'h7777);
      rd_op(16'h0002);
      wr_op(16'hFFF8, 16'h0002);
      idle(8'h3C);

      // Same-cycle read and write
      wr_op(16'h0008, 16'h1111);
      cycle(1'b0, 1'b1, 1'b1, 16'h0008, 16'h2222, sw);
      rd_op(16'h0008);

      // Reset wins over a concurrent LED write
      cycle(1'b1, 1'b0, 1'b1, 16'hFFF0, 16'h00FF, sw);
      idle(8'h3C);
      rd_op(16'hFFF6);
      rd_op(16'hFFF4);
      rd_op(16'hFFF8);

      // Give every RAM word a known value before random reads
      for (int i = 0; i < RAM_BYTES / 2; i++) wr_op(16'(2 * i), 16'($urandom));

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int          kind;
         bit          rd;
         bit          wr;
         bit          rst;
         logic [15:0] a;
         logic [15:0] wd;
         logic [7:0]  swv;
         kind = int'($urandom_range(0, 9));
         if (kind < 4) begin
            a = 16'($urandom_range(0, RAM_BYTES - 1));
            if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
         end else if (kind < 8) begin
            a = IO_BASE + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 5) != 0) a[0] = 1'b0;
         end else begin
            a = 16'($urandom_range(RAM_BYTES, int'(IO_BASE) - 1));
         end
         rd  = ($urandom_range(0, 1) == 1);
         wr  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 299) == 0);
         wd  = 16'($urandom);
         // Keep timer values small so matches actually happen
         if ((a & 16'hFFFE) == IO_BASE + 16'd4 || (a & 16'hFFFE) == IO_BASE + 16'd6)
            wd = 16'($urandom_range(0, 12));
         swv = sw;
         if ($urandom_range(0, 9) == 0) swv = 8'($urandom);
         cycle(rst, rd, wr, a, wd, swv);
      end
      idle(sw);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
